// File: rtl/iso16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : iso16_pkg                                                    |
// | Description : Shared types and helpers for the ISO-16 True Delivery Loop   |
// |               gather path: collector state encoding, default data widths   |
// |               and the flattened-bus slot-slice helper.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package iso16_pkg;

  // Default plugin data widths. The warp components are Q-format numbers.
  // They are treated as opaque bit vectors throughout the gather path.
  localparam int DEF_WARP_WIDTH  = 16;
  localparam int DEF_ERROR_WIDTH = 32;

  // Collector round state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GATHER  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } coll_state_e;

  // LSB of slot idx inside a flattened bus of width-bit slots.
  // iso16_true_delivery uses the same helper, so both sides slice the buses identically.
  function automatic int slot_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iso16_plugin_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iso16_plugin_slot                                            |
// | Description : One plugin channel of the collector. Accepts a single        |
// |               warp/error result per round over valid/ready and holds it    |
// |               until the next accepted arm clears the slot.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst_n        clock, asynchronous active-low reset                   |
// |   clear_i           arm accepted this cycle: drop held result and data     |
// |   gather_i          collector is in GATHER (slot may accept)               |
// |   valid_i/ready_o   plugin handshake; ready_o is combinational             |
// |   warp_*_i, error_i plugin result                                          |
// |   capture_o         handshake completes this cycle                         |
// |   held_o            slot holds a result (registered)                       |
// |   warp_*_o, error_o held result (registered, zero when not captured)       |
// +----------------------------------------------------------------------------+
module iso16_plugin_slot
  import iso16_pkg::*;
#(
  parameter int WARP_WIDTH  = DEF_WARP_WIDTH,
  parameter int ERROR_WIDTH = DEF_ERROR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   gather_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WARP_WIDTH-1:0]  warp_x_i,
  input  logic [WARP_WIDTH-1:0]  warp_y_i,
  input  logic [WARP_WIDTH-1:0]  warp_z_i,
  input  logic [ERROR_WIDTH-1:0] error_i,
  output logic                   capture_o,
  output logic                   held_o,
  output logic [WARP_WIDTH-1:0]  warp_x_o,
  output logic [WARP_WIDTH-1:0]  warp_y_o,
  output logic [WARP_WIDTH-1:0]  warp_z_o,
  output logic [ERROR_WIDTH-1:0] error_o
);

  logic                   held_q;
  logic [WARP_WIDTH-1:0]  warp_x_q;
  logic [WARP_WIDTH-1:0]  warp_y_q;
  logic [WARP_WIDTH-1:0]  warp_z_q;
  logic [ERROR_WIDTH-1:0] error_q;

  // Once a result is held, ready stays low. A plugin that keeps valid
  // asserted stalls and cannot overwrite the first result.
  assign ready_o   = gather_i & ~held_q;
  assign capture_o = valid_i & ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q   <= 1'b0;
      warp_x_q <= '0;
      warp_y_q <= '0;
      warp_z_q <= '0;
      error_q  <= '0;
    end else if (clear_i) begin
      held_q   <= 1'b0;
      warp_x_q <= '0;
      warp_y_q <= '0;
      warp_z_q <= '0;
      error_q  <= '0;
    end else if (capture_o) begin
      held_q   <= 1'b1;
      warp_x_q <= warp_x_i;
      warp_y_q <= warp_y_i;
      warp_z_q <= warp_z_i;
      error_q  <= error_i;
    end
  end

  assign held_o   = held_q;
  assign warp_x_o = warp_x_q;
  assign warp_y_o = warp_y_q;
  assign warp_z_o = warp_z_q;
  assign error_o  = error_q;

endmodule
`default_nettype wire

// File: rtl/iso16_plugin_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iso16_plugin_collector                                       |
// | Description : Upstream gather stage of the ISO-16 True Delivery Loop.      |
// |               Each round collects at most one result per plugin within a   |
// |               bounded window. It then presents the captured set as stable  |
// |               flattened buses, holds start until the loop reports          |
// |               seal_ready (or a timeout expires), and drops start for one   |
// |               cycle before returning to IDLE.                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst_n            clock, asynchronous active-low reset               |
// |   arm                   begin a round (IDLE only)                          |
// |   vector_id_in          vector id, latched on accepted arm                 |
// |   epsilon_in            error bound, latched on accepted arm               |
// |   in_valid/in_ready     per-plugin handshake                               |
// |   in_warp_x/y/z         flattened plugin warps, slot i at [i*W +: W]       |
// |   in_error              flattened plugin errors                            |
// |   seal_ready            loop completion indication (honoured in WAIT)      |
// |   start                 level to the loop                                  |
// |   vector_id, epsilon    latched round parameters                           |
// |   plugin_valid          captured-slot mask                                 |
// |   plugin_warp_*         captured warps; plugin_error captured errors       |
// |   busy                  round in progress (state != IDLE)                  |
// |   gather_timeout        sticky: round launched with a partial mask         |
// |   seal_timeout          sticky: round aborted waiting for seal_ready       |
// |   round_done            one-cycle pulse at the end of a round              |
// +----------------------------------------------------------------------------+
module iso16_plugin_collector
  import iso16_pkg::*;
#(
  parameter int NUM_PLUGINS    = 4,
  parameter int WARP_WIDTH     = DEF_WARP_WIDTH,
  parameter int ERROR_WIDTH    = DEF_ERROR_WIDTH,
  parameter int GATHER_TIMEOUT = 64,
  parameter int SEAL_TIMEOUT   = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arm,
  input  logic [15:0]                        vector_id_in,
  input  logic [ERROR_WIDTH-1:0]             epsilon_in,
  input  logic [NUM_PLUGINS-1:0]             in_valid,
  output logic [NUM_PLUGINS-1:0]             in_ready,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  in_warp_x,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  in_warp_y,
  input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  in_warp_z,
  input  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] in_error,
  input  logic                               seal_ready,
  output logic                               start,
  output logic [15:0]                        vector_id,
  output logic [ERROR_WIDTH-1:0]             epsilon,
  output logic [NUM_PLUGINS-1:0]             plugin_valid,
  output logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_x,
  output logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_y,
  output logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_z,
  output logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error,
  output logic                               busy,
  output logic                               gather_timeout,
  output logic                               seal_timeout,
  output logic                               round_done
);

  // Counter widths. A timeout of 1 still needs one bit.
  localparam int GCW = (GATHER_TIMEOUT > 1) ? $clog2(GATHER_TIMEOUT) : 1;
  localparam int SCW = (SEAL_TIMEOUT > 1) ? $clog2(SEAL_TIMEOUT) : 1;
  localparam logic [GCW-1:0] GATHER_LAST = GCW'(GATHER_TIMEOUT - 1);
  localparam logic [SCW-1:0] SEAL_LAST   = SCW'(SEAL_TIMEOUT - 1);

  coll_state_e state_q, state_d;
  logic [GCW-1:0]         gather_cnt_q, gather_cnt_d;
  logic [SCW-1:0]         seal_cnt_q, seal_cnt_d;
  logic                   start_q, start_d;
  logic                   round_done_q, round_done_d;
  logic                   gather_to_q, gather_to_d;
  logic                   seal_to_q, seal_to_d;
  logic [15:0]            vector_id_q, vector_id_d;
  logic [ERROR_WIDTH-1:0] epsilon_q, epsilon_d;

  logic                   arm_accept;
  logic                   in_gather;
  logic [NUM_PLUGINS-1:0] slot_held;
  logic [NUM_PLUGINS-1:0] slot_capture;
  logic [NUM_PLUGINS-1:0] mask_next;

  assign in_gather = (state_q == ST_GATHER);
  assign mask_next = slot_held | slot_capture;

  // --------------------------------------------------------------------------
  // Plugin channels
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_PLUGINS; i++) begin : g_slot
    iso16_plugin_slot #(
      .WARP_WIDTH (WARP_WIDTH),
      .ERROR_WIDTH(ERROR_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (arm_accept),
      .gather_i (in_gather),
      .valid_i  (in_valid[i]),
      .ready_o  (in_ready[i]),
      .warp_x_i (in_warp_x[slot_lsb(i, WARP_WIDTH) +: WARP_WIDTH]),
      .warp_y_i (in_warp_y[slot_lsb(i, WARP_WIDTH) +: WARP_WIDTH]),
      .warp_z_i (in_warp_z[slot_lsb(i, WARP_WIDTH) +: WARP_WIDTH]),
      .error_i  (in_error[slot_lsb(i, ERROR_WIDTH) +: ERROR_WIDTH]),
      .capture_o(slot_capture[i]),
      .held_o   (slot_held[i]),
      .warp_x_o (plugin_warp_x[slot_lsb(i, WARP_WIDTH) +: WARP_WIDTH]),
      .warp_y_o (plugin_warp_y[slot_lsb(i, WARP_WIDTH) +: WARP_WIDTH]),
      .warp_z_o (plugin_warp_z[slot_lsb(i, WARP_WIDTH) +: WARP_WIDTH]),
      .error_o  (plugin_error[slot_lsb(i, ERROR_WIDTH) +: ERROR_WIDTH])
    );
  end

  // --------------------------------------------------------------------------
  // Round FSM: state and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gather_cnt_q <= '0;
      seal_cnt_q   <= '0;
      start_q      <= 1'b0;
      round_done_q <= 1'b0;
      gather_to_q  <= 1'b0;
      seal_to_q    <= 1'b0;
      vector_id_q  <= '0;
      epsilon_q    <= '0;
    end else begin
      state_q      <= state_d;
      gather_cnt_q <= gather_cnt_d;
      seal_cnt_q   <= seal_cnt_d;
      start_q      <= start_d;
      round_done_q <= round_done_d;
      gather_to_q  <= gather_to_d;
      seal_to_q    <= seal_to_d;
      vector_id_q  <= vector_id_d;
      epsilon_q    <= epsilon_d;
    end
  end

  // --------------------------------------------------------------------------
  // Round FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    gather_cnt_d = gather_cnt_q;
    seal_cnt_d   = seal_cnt_q;
    start_d      = start_q;
    round_done_d = 1'b0;
    gather_to_d  = gather_to_q;
    seal_to_d    = seal_to_q;
    vector_id_d  = vector_id_q;
    epsilon_d    = epsilon_q;
    arm_accept   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          arm_accept   = 1'b1;
          vector_id_d  = vector_id_in;
          epsilon_d    = epsilon_in;
          gather_to_d  = 1'b0;
          seal_to_d    = 1'b0;
          gather_cnt_d = '0;
          state_d      = ST_GATHER;
        end
      end

      ST_GATHER: begin
        gather_cnt_d = gather_cnt_q + GCW'(1);
        // Captures in this cycle count toward completion. A last capture
        // in the expiry cycle is therefore a clean launch, not a timeout.
        if ((&mask_next) || (gather_cnt_q == GATHER_LAST)) begin
          start_d     = 1'b1;
          seal_cnt_d  = '0;
          gather_to_d = ~(&mask_next);
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        seal_cnt_d = seal_cnt_q + SCW'(1);
        if (seal_ready) begin
          start_d      = 1'b0;
          round_done_d = 1'b1;
          state_d      = ST_RELEASE;
        end else if (seal_cnt_q == SEAL_LAST) begin
          start_d      = 1'b0;
          seal_to_d    = 1'b1;
          round_done_d = 1'b1;
          state_d      = ST_RELEASE;
        end
      end

      // One cycle with start low, so the loop's DONE state observes !start
      // before another round can begin.
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign start          = start_q;
  assign round_done     = round_done_q;
  assign gather_timeout = gather_to_q;
  assign seal_timeout   = seal_to_q;
  assign vector_id      = vector_id_q;
  assign epsilon        = epsilon_q;
  assign plugin_valid   = slot_held;
  assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iso16_plugin_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_iso16_plugin_collector                                    |
// | Description : Self-checking bench for iso16_plugin_collector. A table of   |
// |               directed rounds, each with hand-computed latency, mask and   |
// |               flags, followed by a mid-WAIT reset sequence.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_iso16_plugin_collector;

  localparam int NP = 4;
  localparam int W  = 16;
  localparam int E  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arm;
  logic [15:0]     vector_id_in;
  logic [E-1:0]    epsilon_in;
  logic [NP-1:0]   in_valid;
  logic [NP-1:0]   in_ready;
  logic [NP*W-1:0] in_warp_x, in_warp_y, in_warp_z;
  logic [NP*E-1:0] in_error;
  logic            seal_ready;
  logic            start;
  logic [15:0]     vector_id;
  logic [E-1:0]    epsilon;
  logic [NP-1:0]   plugin_valid;
  logic [NP*W-1:0] plugin_warp_x, plugin_warp_y, plugin_warp_z;
  logic [NP*E-1:0] plugin_error;
  logic            busy, gather_timeout, seal_timeout, round_done;

  int checks = 0;
  int errors = 0;

  iso16_plugin_collector #(
    .NUM_PLUGINS   (NP),
    .WARP_WIDTH    (W),
    .ERROR_WIDTH   (E),
    .GATHER_TIMEOUT(8),
    .SEAL_TIMEOUT  (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arm           (arm),
    .vector_id_in  (vector_id_in),
    .epsilon_in    (epsilon_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_warp_x     (in_warp_x),
    .in_warp_y     (in_warp_y),
    .in_warp_z     (in_warp_z),
    .in_error      (in_error),
    .seal_ready    (seal_ready),
    .start         (start),
    .vector_id     (vector_id),
    .epsilon       (epsilon),
    .plugin_valid  (plugin_valid),
    .plugin_warp_x (plugin_warp_x),
    .plugin_warp_y (plugin_warp_y),
    .plugin_warp_z (plugin_warp_z),
    .plugin_error  (plugin_error),
    .busy          (busy),
    .gather_timeout(gather_timeout),
    .seal_timeout  (seal_timeout),
    .round_done    (round_done)
  );

  always #5 clk = ~clk;

  // One round: inputs plus hand-computed expectations.
  // Slots in avail present valid from GATHER cycle 0. Slots in late present
  // valid from GATHER cycle late_cyc. seal_d is the WAIT cycle index carrying
  // seal_ready (-1 = never). exp_start counts GATHER cycles until start.
  // exp_wait counts WAIT cycles.
  typedef struct {
    logic [15:0] vid;
    logic [31:0] eps;
    logic [15:0] xbase;
    logic [3:0]  avail;
    logic [3:0]  late;
    int          late_cyc;
    int          seal_d;
    logic [3:0]  exp_mask;
    logic        exp_gto;
    logic        exp_sto;
    int          exp_start;
    int          exp_wait;
  } vec_t;

  vec_t vecs[5];

  // Plugin data depends on the GATHER cycle, so a slot's held value shows
  // which cycle it was captured in.
  function automatic logic [15:0] fx(input logic [15:0] base, input int i, input int g);
    return base + 16'(i + 1) + 16'(g << 4);
  endfunction
  function automatic logic [15:0] fy(input logic [15:0] base, input int i, input int g);
    return fx(base, i, g) ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] fz(input logic [15:0] base, input int i, input int g);
    return fx(base, i, g) + 16'h0100;
  endfunction
  function automatic logic [31:0] fe(input logic [15:0] base, input int i, input int g);
    return {fx(base, i, g), ~fx(base, i, g)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_data(input logic [15:0] base, input int g);
    for (int i = 0; i < NP; i++) begin
      in_warp_x[i*W +: W] = fx(base, i, g);
      in_warp_y[i*W +: W] = fy(base, i, g);
      in_warp_z[i*W +: W] = fz(base, i, g);
      in_error[i*E +: E]  = fe(base, i, g);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vector_id"}, vector_id, 0);
    chk({tag, "_epsilon"}, epsilon, 0);
    chk({tag, "_plugin_valid"}, plugin_valid, 0);
    chk({tag, "_warp_x"}, plugin_warp_x, 0);
    chk({tag, "_warp_y"}, plugin_warp_y, 0);
    chk({tag, "_warp_z"}, plugin_warp_z, 0);
    chk({tag, "_error"}, plugin_error, 0);
    chk({tag, "_gto"}, gather_timeout, 0);
    chk({tag, "_sto"}, seal_timeout, 0);
    chk({tag, "_round_done"}, round_done, 0);
  endtask

  task automatic check_buses(input string tag, input logic [63:0] ex, input logic [63:0] ey,
                             input logic [63:0] ez, input logic [127:0] ee);
    chk({tag, "_warp_x"}, plugin_warp_x, ex);
    chk({tag, "_warp_y"}, plugin_warp_y, ey);
    chk({tag, "_warp_z"}, plugin_warp_z, ez);
    chk({tag, "_error"}, plugin_error, ee);
  endtask

  task automatic run_round(input vec_t v);
    logic [3:0]   mask_m, cur, exp_rdy;
    logic [63:0]  ex_x, ex_y, ex_z;
    logic [127:0] ex_e;
    int           cap_g[NP];
    int           g, w;
    bit           started, ended;

    vector_id_in = v.vid;
    epsilon_in   = v.eps;
    in_valid     = '0;
    seal_ready   = 1'b0;
    drive_data(v.xbase, 0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_start", start, 0);
    chk("arm_mask_clear", plugin_valid, 0);
    chk("arm_gto_clear", gather_timeout, 0);
    chk("arm_sto_clear", seal_timeout, 0);
    chk("arm_vector_id", vector_id, v.vid);

    // GATHER
    mask_m  = '0;
    g       = 0;
    started = 1'b0;
    for (int i = 0; i < NP; i++) cap_g[i] = 0;
    while (!started && g < 40) begin
      cur     = v.avail | ((g >= v.late_cyc) ? v.late : 4'h0);
      exp_rdy = ~mask_m;
      chk("gather_in_ready", in_ready, exp_rdy);
      for (int i = 0; i < NP; i++)
        if (cur[i] && !mask_m[i]) cap_g[i] = g;
      mask_m   = mask_m | cur;
      in_valid = cur;
      drive_data(v.xbase, g);
      tick();
      g++;
      started = start;
    end
    if (!started) begin
      checks++;
      errors++;
      $display("FAIL start_rise_timeout: start low after %0d GATHER cycles, required high after %0d",
               g, v.exp_start);
    end

    ex_x = '0; ex_y = '0; ex_z = '0; ex_e = '0;
    for (int i = 0; i < NP; i++) begin
      if (v.exp_mask[i]) begin
        ex_x[i*W +: W] = fx(v.xbase, i, cap_g[i]);
        ex_y[i*W +: W] = fy(v.xbase, i, cap_g[i]);
        ex_z[i*W +: W] = fz(v.xbase, i, cap_g[i]);
        ex_e[i*E +: E] = fe(v.xbase, i, cap_g[i]);
      end
    end

    chk("start_latency", g, v.exp_start);
    chk("launch_mask", plugin_valid, v.exp_mask);
    chk("launch_gto", gather_timeout, v.exp_gto);
    chk("wait_in_ready", in_ready, 0);
    chk("launch_epsilon", epsilon, v.eps);
    check_buses("launch", ex_x, ex_y, ex_z, ex_e);

    // WAIT: plugins keep pushing new data and an arm pulse arrives with a
    // different id. None of that may disturb the launched set.
    w        = 0;
    ended    = 1'b0;
    in_valid = 4'hF;
    while (!ended && w < 100) begin
      seal_ready   = (w == v.seal_d);
      arm          = (w == 1);
      vector_id_in = 16'hBAD0;
      epsilon_in   = 32'h0BAD_0BAD;
      drive_data(v.xbase, g + w + 1);
      tick();
      ended = !start;
      w++;
    end
    arm        = 1'b0;
    seal_ready = 1'b0;
    in_valid   = '0;
    chk("wait_cycles", w, v.exp_wait);

    // RELEASE
    chk("release_round_done", round_done, 1);
    chk("release_busy", busy, 1);
    chk("release_sto", seal_timeout, v.exp_sto);
    chk("release_gto", gather_timeout, v.exp_gto);
    chk("release_vector_id", vector_id, v.vid);
    chk("release_epsilon", epsilon, v.eps);
    chk("release_mask", plugin_valid, v.exp_mask);
    check_buses("release", ex_x, ex_y, ex_z, ex_e);

    tick();
    chk("idle_round_done", round_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_start", start, 0);
    chk("idle_mask_held", plugin_valid, v.exp_mask);
    chk("idle_vector_id", vector_id, v.vid);
  endtask

  initial begin
    //           vid       eps           xbase    avail  late   lc  seal  mask   gto   sto   st  wait
    vecs[0] = '{16'h1111, 32'hDEADBEEF, 16'h0000, 4'hF, 4'h0, 0,  12, 4'hF, 1'b0, 1'b0, 1, 13};
    vecs[1] = '{16'h2222, 32'h00000010, 16'h1000, 4'h5, 4'h0, 0,  3,  4'h5, 1'b1, 1'b0, 8, 4};
    vecs[2] = '{16'h3333, 32'h00000020, 16'h2000, 4'h7, 4'h8, 7,  0,  4'hF, 1'b0, 1'b0, 8, 1};
    vecs[3] = '{16'h4444, 32'h00000030, 16'h3000, 4'h2, 4'hD, 2,  -1, 4'hF, 1'b0, 1'b1, 3, 32};
    vecs[4] = '{16'h5555, 32'h00000040, 16'h4000, 4'h0, 4'h0, 0,  5,  4'h0, 1'b1, 1'b0, 8, 6};

    rst_n        = 1'b0;
    arm          = 1'b0;
    vector_id_in = '0;
    epsilon_in   = '0;
    in_valid     = '0;
    seal_ready   = 1'b0;
    in_warp_x    = '0;
    in_warp_y    = '0;
    in_warp_z    = '0;
    in_error     = '0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_round(vecs[k]);

    // Reset in the middle of WAIT.
    vector_id_in = 16'h7777;
    epsilon_in   = 32'h77777777;
    drive_data(16'h7000, 0);
    arm = 1'b1;
    tick();
    arm      = 1'b0;
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    chk("mid_start_high", start, 1);
    chk("mid_mask", plugin_valid, 4'hF);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    tick();
    chk("reset_hold_round_done", round_done, 0);
    tick();
    chk("reset_hold_round_done2", round_done, 0);
    rst_n = 1'b1;
    tick();
    run_round('{16'h8888, 32'h88888888, 16'h0000, 4'hF, 4'h0, 0, 2, 4'hF, 1'b0, 1'b0, 1, 3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog, so a stuck bench always ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
